// File: rtl/falu_pkg.sv
// Shared definitions for the FALU scheduler: opcodes, FSM encoding, flag bundle, legality check.
package falu_pkg;

  localparam logic [3:0] FOP_IDLE = 4'd0;
  localparam logic [3:0] FOP_MUL  = 4'd1;
  localparam logic [3:0] FOP_DIV  = 4'd2;
  localparam logic [3:0] FOP_SUB  = 4'd3;
  localparam logic [3:0] FOP_OR   = 4'd4;
  localparam logic [3:0] FOP_AND  = 4'd5;
  localparam logic [3:0] FOP_XOR  = 4'd6;
  localparam logic [3:0] FOP_SHL1 = 4'd7;
  localparam logic [3:0] FOP_SHR1 = 4'd8;
  localparam logic [3:0] FOP_F2I  = 4'd9;
  localparam logic [3:0] FOP_ADD  = 4'd10;
  localparam logic [3:0] FOP_NOT  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
  } falu_flags_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= FOP_MUL) && (op <= FOP_NOT);
  endfunction

endpackage

// File: rtl/falu_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping) wins.
module falu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/falu_scheduler.sv
// Time-shares one combinational FALU between NUM_REQ requesters with a settle window.
// Optional FALU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags accumulation of captured flags.
module falu_scheduler
  import falu_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_exc,
  output logic                  rsp_ovf,
  output logic                  rsp_unf,
  output logic [3:0]            falu_op,
  output logic [31:0]           falu_a,
  output logic [31:0]           falu_b,
  input  logic [31:0]           falu_result,
  input  logic                  falu_exc,
  input  logic                  falu_ovf,
  input  logic                  falu_unf,
`ifdef FALU_STICKY_FLAGS_EN
  input  logic                  sticky_clr,
  output logic [2:0]            sticky_flags,
`endif
  output logic                  busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        result_q;
  falu_flags_t        flags_q;
  falu_flags_t        cap_flags;
  logic               cap_en;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic [3:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               sel_legal;

  falu_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign sel_op    = req_op[int'(arb_idx)*4 +: 4];
  assign sel_a     = req_a[int'(arb_idx)*32 +: 32];
  assign sel_b     = req_b[int'(arb_idx)*32 +: 32];
  assign sel_legal = is_legal_op(sel_op);

  // Illegal ops are answered immediately with exc; legal ops capture after the settle window.
  always_comb begin
    cap_en    = 1'b0;
    cap_flags = '0;
    if (state == ST_IDLE && arb_valid && !sel_legal) begin
      cap_en        = 1'b1;
      cap_flags.exc = 1'b1;
    end else if (state == ST_EXEC && cnt == '0) begin
      cap_en        = 1'b1;
      cap_flags.exc = falu_exc;
      cap_flags.ovf = falu_ovf;
      cap_flags.unf = falu_unf;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      cnt      <= '0;
      op_q     <= FOP_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_idx;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            if (sel_legal) begin
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= ST_EXEC;
            end else begin
              result_q <= '0;
              flags_q  <= cap_flags;
              state    <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            result_q <= falu_result;
            flags_q  <= cap_flags;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_id]) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign req_ready  = (state == ST_IDLE) ? arb_grant : '0;
  assign rsp_valid  = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign rsp_result = result_q;
  assign rsp_exc    = flags_q.exc;
  assign rsp_ovf    = flags_q.ovf;
  assign rsp_unf    = flags_q.unf;
  assign falu_op    = (state == ST_EXEC) ? op_q : FOP_IDLE;
  assign falu_a     = (state == ST_EXEC) ? a_q : '0;
  assign falu_b     = (state == ST_EXEC) ? b_q : '0;

`ifdef FALU_STICKY_FLAGS_EN
  logic [2:0] sticky_q;

  // A clear on the same edge as a capture keeps only the newly captured flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= (sticky_clr ? 3'b000 : sticky_q) | (cap_en ? cap_flags : 3'b000);
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_falu_scheduler.sv
// Scoreboard bench for falu_scheduler with a behavioural stand-in FALU.
// Sticky-flag checks are compiled in when FALU_STICKY_FLAGS_EN is defined.
module tb_falu_scheduler;

  localparam int NUM_REQ = 2;
  localparam int SETTLE  = 3;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op = '0;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready = '0;
  logic [31:0]           rsp_result;
  logic                  rsp_exc, rsp_ovf, rsp_unf;
  logic [3:0]            falu_op;
  logic [31:0]           falu_a, falu_b, falu_result;
  logic                  falu_exc, falu_ovf, falu_unf;
  logic                  busy;
`ifdef FALU_STICKY_FLAGS_EN
  logic                  sticky_clr = 1'b0;
  logic [2:0]            sticky_flags;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  exp_t sb[$];
  int   grant_log[$];
  int   accept_cyc[$];

  falu_scheduler #(.NUM_REQ(NUM_REQ), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_exc(rsp_exc), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf),
    .falu_op(falu_op), .falu_a(falu_a), .falu_b(falu_b), .falu_result(falu_result),
    .falu_exc(falu_exc), .falu_ovf(falu_ovf), .falu_unf(falu_unf),
`ifdef FALU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Stand-in FALU: deterministic per-op results with flags that exercise capture.
  function automatic logic [34:0] falu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic exc, ovf, unf;
    r = '0; exc = 1'b0; ovf = 1'b0; unf = 1'b0;
    case (op)
      4'd1:  begin r = a * b; ovf = a[30] & b[30]; end
      4'd2:  if (b[30:0] == 31'd0) begin r = 32'h7F80_0000; exc = 1'b1; end else r = a ^ b;
      4'd3:  begin r = a - b; unf = (a < b); end
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd6:  r = a ^ b;
      4'd7:  r = a << 1;
      4'd8:  r = a >> 1;
      4'd9:  r = {24'd0, a[30:23]};
      4'd10: r = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
      4'd11: r = ~a;
      default: begin r = 32'hDEAD_0000 | {28'd0, op}; exc = 1'b1; ovf = 1'b1; unf = 1'b1; end
    endcase
    return {unf, ovf, exc, r};
  endfunction

  always_comb {falu_unf, falu_ovf, falu_exc, falu_result} = falu_model(falu_op, falu_a, falu_b);

  function automatic exp_t exp_of(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id = id;
    if (op == 4'd0 || op > 4'd11) begin
      e.res = '0; e.exc = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
    end else begin
      {e.unf, e.ovf, e.exc, e.res} = falu_model(op, a, b);
    end
    return e;
  endfunction

  task automatic push_exp(input int id);
    sb.push_back(exp_of(id, req_op[id*4 +: 4], req_a[id*32 +: 32], req_b[id*32 +: 32]));
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[id*4 +: 4]   = op;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
    req_valid[id]       = 1'b1;
  endtask

  // Response handshakes are scored against the queue as they happen.
  always @(negedge CLK) begin
    if (!RESET && (rsp_valid & rsp_ready) != '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_valid !== (2'b01 << e.id) || rsp_result !== e.res ||
            {rsp_exc, rsp_ovf, rsp_unf} !== {e.exc, e.ovf, e.unf}) begin
          miscompares++;
          $display("[TB] FAIL rsp_data: got valid=%b res=%h flags=%b, expected valid=%b res=%h flags=%b",
                   rsp_valid, rsp_result, {rsp_exc, rsp_ovf, rsp_unf},
                   2'b01 << e.id, e.res, {e.exc, e.ovf, e.unf});
        end
      end
    end
  end

  // Drives nothing but handshakes: waits for up to n grants, logging order and accept cycle.
  task automatic serve_pending(input int n, input bit push);
    int got, cyc, id;
    got = 0; cyc = 0;
    grant_log.delete();
    while (got < n && cyc < 60) begin
      @(negedge CLK);
      if (req_ready != '0) begin
        id = req_ready[1] ? 1 : 0;
        grant_log.push_back(id);
        if (push) push_exp(id);
        @(posedge CLK); #1;
        accept_cyc.push_back(cycle);
        req_valid[id] = 1'b0;
        req_a[id*32 +: 32] = $urandom;
        req_b[id*32 +: 32] = $urandom;
        got++;
      end else begin
        @(posedge CLK); #1;
      end
      cyc++;
    end
  endtask

  task automatic wait_drain(output bit ok);
    int cyc;
    cyc = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || busy) && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    ok = (sb.size() == 0) && !busy;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({busy, req_ready, rsp_valid, rsp_result, rsp_exc, rsp_ovf, rsp_unf, falu_op, falu_a, falu_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: busy=%b req_ready=%b rsp_valid=%b res=%h falu_op=%h, expected all 0",
               busy, req_ready, rsp_valid, rsp_result, falu_op);
    end
`ifdef FALU_STICKY_FLAGS_EN
    vectors++;
    if (sticky_flags !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_sticky: got %b, expected 000", sticky_flags);
    end
`endif
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    int lat;
    exp_t e;
    bit ok;
    rsp_ready = '1;
    set_req(0, 4'd10, 32'h3F80_0000, 32'h4000_0000);
    @(negedge CLK);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL add_req_ready: got %b, expected 01", req_ready);
    end
    e.id = 0; e.res = 32'h4040_0000; e.exc = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
    sb.push_back(e);
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    req_a[31:0]  = 32'h1234_5678;
    req_b[31:0]  = 32'h8765_4321;
    lat = 1;
    @(negedge CLK);
    vectors++;
    if (falu_op !== 4'd10 || falu_a !== 32'h3F80_0000 || falu_b !== 32'h4000_0000) begin
      miscompares++;
      $display("[TB] FAIL add_falu_drive: got op=%h a=%h b=%h, expected op=a a=3f800000 b=40000000",
               falu_op, falu_a, falu_b);
    end
    while (rsp_valid[0] !== 1'b1 && lat < 20) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
    end
    vectors++;
    if (lat != SETTLE + 1) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got %0d, expected %0d", lat, SETTLE + 1);
    end
    @(posedge CLK); #1;
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL add_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    rsp_ready = '1;
    for (int rep = 0; rep < 2; rep++) begin
      set_req(0, 4'd5, $urandom, $urandom);
      set_req(1, 4'd6, $urandom, $urandom);
      serve_pending(2, 1'b1);
      vectors++;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
        miscompares++;
        $display("[TB] FAIL rr_order rep%0d: got %0d grants first=%0d, expected 2 grants 0 then 1",
                 rep, grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
      end
      wait_drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL rr_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
    end
  endtask

  task automatic test_illegal();
    int lat;
    bit falu_seen, ok;
    rsp_ready = '1;
    falu_seen = 1'b0;
    set_req(1, 4'd12, $urandom, $urandom);
    @(negedge CLK);
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL illegal_req_ready: got %b, expected 10", req_ready);
    end
    push_exp(1);
    @(posedge CLK); #1;
    req_valid[1] = 1'b0;
    lat = 1;
    @(negedge CLK);
    if (falu_op !== 4'd0) falu_seen = 1'b1;
    while (rsp_valid[1] !== 1'b1 && lat < 20) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (falu_op !== 4'd0) falu_seen = 1'b1;
    end
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("[TB] FAIL illegal_latency: got %0d, expected 1", lat);
    end
    repeat (3) begin
      @(negedge CLK);
      if (falu_op !== 4'd0) falu_seen = 1'b1;
    end
    vectors++;
    if (falu_seen) begin
      miscompares++;
      $display("[TB] FAIL illegal_falu_op: got nonzero falu_op, expected 0 throughout");
    end
    @(posedge CLK); #1;
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL illegal_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
  endtask

  task automatic test_div_zero();
    bit ok;
    rsp_ready = '1;
`ifdef FALU_STICKY_FLAGS_EN
    sticky_clr = 1'b1;
    @(posedge CLK); #1;
    sticky_clr = 1'b0;
    @(negedge CLK);
    vectors++;
    if (sticky_flags !== 3'b000) begin miscompares++; $display("[TB] FAIL sticky_clear0: got %b, expected 000", sticky_flags); end
    @(posedge CLK); #1;
`endif
    set_req(0, 4'd2, 32'h3F80_0000, 32'h0000_0000);
    serve_pending(1, 1'b1);
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL div_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
    set_req(0, 4'd1, 32'h7F00_0000, 32'h7F00_0000);
    serve_pending(1, 1'b1);
    wait_drain(ok);
`ifdef FALU_STICKY_FLAGS_EN
    vectors++;
    if (sticky_flags !== 3'b110) begin miscompares++; $display("[TB] FAIL sticky_accum: got %b, expected 110", sticky_flags); end
`endif
    // Illegal op captures on its accept edge; clearing on that edge must leave only exc.
    set_req(1, 4'd13, $urandom, $urandom);
    @(negedge CLK);
    vectors++;
    if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL clr_cap_ready: got %b, expected 10", req_ready); end
    push_exp(1);
`ifdef FALU_STICKY_FLAGS_EN
    sticky_clr = 1'b1;
`endif
    @(posedge CLK); #1;
`ifdef FALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    req_valid[1] = 1'b0;
    wait_drain(ok);
`ifdef FALU_STICKY_FLAGS_EN
    vectors++;
    if (sticky_flags !== 3'b100) begin miscompares++; $display("[TB] FAIL sticky_clr_capture: got %b, expected 100", sticky_flags); end
    sticky_clr = 1'b1;
    @(posedge CLK); #1;
    sticky_clr = 1'b0;
    @(negedge CLK);
    vectors++;
    if (sticky_flags !== 3'b000) begin miscompares++; $display("[TB] FAIL sticky_clear: got %b, expected 000", sticky_flags); end
    @(posedge CLK); #1;
`endif
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc;
    bit ok;
    rsp_ready = 2'b00;
    set_req(0, 4'd6, 32'hA5A5_0F0F, 32'h0FF0_1234);
    e = exp_of(0, 4'd6, 32'hA5A5_0F0F, 32'h0FF0_1234);
    serve_pending(1, 1'b1);
    set_req(1, 4'd4, $urandom, $urandom);
    rsp_ready = 2'b10;
    cyc = 0;
    @(negedge CLK);
    while (rsp_valid !== 2'b01 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    vectors++;
    if (cyc >= 20) begin miscompares++; $display("[TB] FAIL bp_rsp_timeout: got no rsp_valid, expected 01"); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || req_ready !== 2'b00 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b res=%h ready=%b busy=%b, expected 01 %h 00 1",
                 i, rsp_valid, rsp_result, req_ready, busy, e.res);
      end
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    rsp_ready = 2'b11;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got busy=%b ready=%b valid=%b, expected 0 10 00", busy, req_ready, rsp_valid);
    end
    push_exp(1);
    @(posedge CLK); #1;
    req_valid[1] = 1'b0;
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL bp_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4];
    bit ok;
    ops[0] = 4'd1; ops[1] = 4'd11; ops[2] = 4'd9; ops[3] = 4'd3;
    rsp_ready = '1;
    accept_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      set_req(0, ops[i], $urandom, $urandom);
      serve_pending(1, 1'b1);
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (accept_cyc.size() != 4 || accept_cyc[i] - accept_cyc[i-1] != SETTLE + 2) begin
        miscompares++;
        $display("[TB] FAIL b2b_interval%0d: got %0d accepts, gap %0d, expected gap %0d", i, accept_cyc.size(),
                 (accept_cyc.size() > i) ? accept_cyc[i] - accept_cyc[i-1] : -1, SETTLE + 2);
      end
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL b2b_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
  endtask

  task automatic test_reset_mid_exec();
    bit seen, ok;
    rsp_ready = '1;
    set_req(1, 4'd10, $urandom, $urandom);
    serve_pending(1, 1'b0);
    @(posedge CLK); #2;
    RESET = 1'b1;
    #1;
    vectors++;
    if ({busy, req_ready, rsp_valid, rsp_result, rsp_exc, rsp_ovf, rsp_unf, falu_op, falu_a, falu_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: busy=%b rsp_valid=%b falu_op=%h falu_a=%h, expected all 0",
               busy, rsp_valid, falu_op, falu_a);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("[TB] FAIL midreset_quiet: got activity after reset, expected none"); end
    @(posedge CLK); #1;
    set_req(0, 4'd7, $urandom, $urandom);
    set_req(1, 4'd8, $urandom, $urandom);
    serve_pending(2, 1'b1);
    vectors++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_first: got %0d grants first=%0d, expected first grant 0",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL midreset_drain: got busy=%b pending=%0d, expected idle", busy, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_illegal();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
